// File: rtl/fret_sprite_scheduler_if.sv
// Bus bundle between the video timing / game-state side and the fret sprite
// scheduler. The master drives raster position, fret state and ROM data; the
// scheduler (slave) returns the ROM address and the final pixel.
interface fret_sprite_scheduler_if #(
  parameter int N_FRETS = 5
) ();
  logic [10:0]           hcount;
  logic [9:0]            vcount;
  logic [10*N_FRETS-1:0] fret_x;
  logic [N_FRETS-1:0]    pressed;
  logic [N_FRETS-1:0]    hit;
  logic [11:0]           paddr;
  logic [12:0]           pdata;
  logic [12:0]           pixel;
  logic                  active;

  modport master (
    output hcount, vcount, fret_x, pressed, hit, pdata,
    input  paddr, pixel, active
  );

  modport slave (
    input  hcount, vcount, fret_x, pressed, hit, pdata,
    output paddr, pixel, active
  );
endinterface

// File: rtl/fret_sprite_scheduler.sv
// Shares one synchronous-read fret sprite ROM among the frets of the fret row.
// Fret positions and button state are shadowed once per video frame; a per-fret
// flash timer selects the hit sprite. Pipeline: hcount -> paddr (1 clk) ->
// pdata (ROM, 1 clk) -> pixel (1 clk), 3 clk total.
module fret_sprite_scheduler #(
  parameter int          N_FRETS      = 5,
  parameter int          Y            = 512,
  parameter int          W            = 32,
  parameter int          H            = 32,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [12:0] TRANSPARENT  = 13'h0000
) (
  input logic                   i_clk,
  input logic                   i_rst,
  fret_sprite_scheduler_if.slave bus
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);

  logic [9:0]         r_shadow_x [N_FRETS];
  logic [N_FRETS-1:0] r_shadow_pressed;
  logic               r_shadow_valid;
  logic [FW-1:0]      r_flash [N_FRETS];
  logic [N_FRETS-1:0] r_hit_pending;

  logic [11:0] r_paddr;
  logic        r_v1;
  logic        r_v2;
  logic [12:0] r_pixel;
  logic        r_active;

  logic               w_fs;
  logic [9:0]         w_yidx;
  logic [10:0]        w_xidx [N_FRETS];
  logic [1:0]         w_frame [N_FRETS];
  logic [N_FRETS-1:0] w_in;
  logic               w_win;
  logic [4:0]         w_xidx_w;
  logic [1:0]         w_frame_w;

  assign w_fs   = (bus.hcount == 11'd0) && (bus.vcount == 10'd0);
  assign w_yidx = bus.vcount - 10'(Y);

  // Shadow fret state and advance flash timers once per frame; collect hits any cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_FRETS; i++) begin
        r_shadow_x[i] <= '0;
        r_flash[i]    <= '0;
      end
      r_shadow_pressed <= '0;
      r_shadow_valid   <= 1'b0;
      r_hit_pending    <= '0;
    end else if (w_fs) begin
      for (int i = 0; i < N_FRETS; i++) begin
        r_shadow_x[i] <= bus.fret_x[10*i +: 10];
        if (r_hit_pending[i])
          r_flash[i] <= FW'(FLASH_FRAMES);
        else if (r_flash[i] != '0)
          r_flash[i] <= r_flash[i] - FW'(1);
      end
      r_shadow_pressed <= bus.pressed;
      r_shadow_valid   <= 1'b1;
      // A hit landing on the frame-start cycle waits for the following frame.
      r_hit_pending    <= bus.hit;
    end else begin
      r_hit_pending <= r_hit_pending | bus.hit;
    end
  end

  // Per-fret coverage test and sprite frame selection.
  always_comb begin
    for (int i = 0; i < N_FRETS; i++) begin
      w_xidx[i]  = bus.hcount - {1'b0, r_shadow_x[i]};
      w_in[i]    = r_shadow_valid && (w_xidx[i] < 11'(W)) && (w_yidx < 10'(H));
      w_frame[i] = (r_flash[i] != '0) ? 2'd2 : (r_shadow_pressed[i] ? 2'd1 : 2'd0);
    end
  end

  // Fixed priority by coverage only: scanning downward leaves the lowest index.
  always_comb begin
    w_win     = 1'b0;
    w_xidx_w  = '0;
    w_frame_w = '0;
    for (int i = N_FRETS - 1; i >= 0; i--) begin
      if (w_in[i]) begin
        w_win     = 1'b1;
        w_xidx_w  = w_xidx[i][4:0];
        w_frame_w = w_frame[i];
      end
    end
  end

  // ROM address stage and valid pipeline alongside the ROM read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_paddr <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
    end else begin
      r_paddr <= w_win ? {w_frame_w, w_yidx[4:0], w_xidx_w} : 12'd0;
      r_v1    <= w_win;
      r_v2    <= r_v1;
    end
  end

  // Output stage: a covered pixel passes ROM data through even if it is transparent.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pixel  <= TRANSPARENT;
      r_active <= 1'b0;
    end else begin
      r_pixel  <= r_v2 ? bus.pdata : TRANSPARENT;
      r_active <= r_v2;
    end
  end

  assign bus.paddr  = r_paddr;
  assign bus.pixel  = r_pixel;
  assign bus.active = r_active;

endmodule

// File: tb/tb_fret_sprite_scheduler.sv
// Bench for the fret sprite scheduler: directed raster probes followed by
// randomized frames, checked against a coverage/priority model of the fret row.
module tb_fret_sprite_scheduler;
  localparam int N   = 5;
  localparam int Y   = 512;
  localparam int W   = 32;
  localparam int H   = 32;
  localparam int FF  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fret_sprite_scheduler_if #(.N_FRETS(N)) bus ();

  fret_sprite_scheduler #(.N_FRETS(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [12:0] rom [4096];
  always @(posedge clk) bus.pdata <= rom[bus.paddr];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what the fret row should look like this frame.
  int m_x [N];
  int m_pressed [N];
  int m_flash [N];
  int m_pend [N];
  bit m_valid;

  logic [11:0] last_paddr;
  logic [12:0] last_pixel;
  logic        last_active;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_pix(input int h, input int v, output bit found, output logic [11:0] addr);
    int fr;
    found = 0;
    addr  = '0;
    if (!m_valid) return;
    for (int i = 0; i < N; i++) begin
      if (!found && v >= Y && v < Y + H && h >= m_x[i] && h < m_x[i] + W) begin
        found = 1;
        fr    = (m_flash[i] > 0) ? 2 : (m_pressed[i] != 0 ? 1 : 0);
        addr  = 12'(fr * 1024 + (v - Y) * 32 + (h - m_x[i]));
      end
    end
  endfunction

  task automatic model_reset();
    m_valid = 0;
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_pressed[i] = 0; m_flash[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic set_fret(input int i, input int x);
    bus.fret_x[10*i +: 10] = 10'(x);
  endtask

  task automatic frame_start(input logic [N-1:0] hit_mask);
    bus.hcount = 11'd0;
    bus.vcount = 10'd0;
    bus.hit    = hit_mask;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      m_x[i]       = int'(bus.fret_x[10*i +: 10]);
      m_pressed[i] = int'(bus.pressed[i]);
      if (m_pend[i] != 0) m_flash[i] = FF;
      else if (m_flash[i] > 0) m_flash[i]--;
      m_pend[i] = int'(hit_mask[i]);
    end
    m_valid    = 1;
    bus.hit    = '0;
    bus.hcount = 11'd1500;
    bus.vcount = 10'd1;
  endtask

  task automatic pulse_hit(input logic [N-1:0] mask);
    bus.hit = mask;
    @(posedge clk); #1;
    bus.hit = '0;
    for (int i = 0; i < N; i++) if (mask[i]) m_pend[i] = 1;
  endtask

  task automatic probe(input int h, input int v);
    bit          found;
    logic [11:0] addr;
    model_pix(h, v, found, addr);
    bus.hcount = 11'(h);
    bus.vcount = 10'(v);
    @(posedge clk); #1;
    last_paddr = bus.paddr;
    chk("paddr", 16'(bus.paddr), found ? 16'(addr) : 16'h0);
    bus.hcount = 11'd1500;
    bus.vcount = 10'd1;
    @(posedge clk); #1;
    chk("active_early", 16'(bus.active), 16'h0);
    @(posedge clk); #1;
    last_pixel  = bus.pixel;
    last_active = bus.active;
    chk("active", 16'(bus.active), 16'(found));
    chk("pixel", 16'(bus.pixel), found ? 16'(rom[addr]) : 16'h0);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) rom[a] = 13'($urandom);
    rom[0] = 13'h1ABC;
    model_reset();
    bus.hcount  = 11'd1500;
    bus.vcount  = 10'd1;
    bus.pressed = '0;
    bus.hit     = '0;
    bus.fret_x  = '0;
    set_fret(0, 100); set_fret(1, 600); set_fret(2, 300); set_fret(3, 400); set_fret(4, 1020);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_paddr", 16'(bus.paddr), 16'h0);
    chk("rst_pixel", 16'(bus.pixel), 16'h0);
    chk("rst_active", 16'(bus.active), 16'h0);
    rst = 1'b0;

    // No frame-start yet: nothing may be drawn on the fret row.
    for (int h = 90; h < 290; h++) begin
      bus.hcount = 11'(h);
      bus.vcount = 10'd512;
      @(posedge clk); #1;
      chk("noshadow_active", 16'(bus.active), 16'h0);
      chk("noshadow_pixel", 16'(bus.pixel), 16'h0);
    end

    frame_start('0);
    probe(100, 512);
    chk("first_paddr", 16'(last_paddr), 16'h000);
    chk("first_pixel", 16'(last_pixel), 16'h1ABC);
    probe(99, 512);  chk("left_edge", 16'(last_active), 16'h0);
    probe(132, 512); chk("right_edge", 16'(last_active), 16'h0);
    probe(100, 511); chk("top_edge", 16'(last_active), 16'h0);
    probe(100, 544); chk("bottom_edge", 16'(last_active), 16'h0);
    probe(5, 512);   chk("no_wrap", 16'(last_active), 16'h0);
    probe(131, 543); chk("corner_in", 16'(last_active), 16'h1);

    // Moving fret 1 mid-frame must not show until the next frame-start.
    set_fret(1, 110);
    probe(135, 520); chk("midframe_x", 16'(last_active), 16'h0);
    frame_start('0);
    probe(115, 520); chk("overlap_f0", 16'(last_paddr), 16'h10F);
    probe(135, 520); chk("overlap_f1", 16'(last_paddr), 16'h119);

    bus.pressed = 5'b00100;
    frame_start('0);
    probe(300, 512); chk("pressed", 16'(last_paddr), 16'h400);
    bus.pressed = '0;
    probe(300, 512); chk("pressed_hold", 16'(last_paddr), 16'h400);
    frame_start('0);
    probe(300, 512); chk("released", 16'(last_paddr), 16'h000);

    // Hit flash lasts exactly FF frames starting at the next frame-start.
    pulse_hit(5'b01000);
    probe(400, 512); chk("hit_pending", 16'(last_paddr[11:10]), 16'd0);
    for (int k = 0; k < FF + 2; k++) begin
      frame_start('0);
      probe(400, 512);
      chk("flash_frame", 16'(last_paddr[11:10]), (k < FF) ? 16'd2 : 16'd0);
    end
    frame_start(5'b01000);
    probe(400, 512); chk("fs_hit_delayed", 16'(last_paddr[11:10]), 16'd0);
    frame_start('0);
    probe(400, 512); chk("fs_hit_flash", 16'(last_paddr[11:10]), 16'd2);

    // Async reset in the middle of a drawn span.
    bus.pressed = 5'b00001;
    frame_start('0);
    bus.hcount = 11'd100;
    bus.vcount = 10'd512;
    repeat (3) @(posedge clk);
    #1;
    chk("predraw_paddr", 16'(bus.paddr), 16'h400);
    chk("predraw_active", 16'(bus.active), 16'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_paddr", 16'(bus.paddr), 16'h0);
    chk("async_pixel", 16'(bus.pixel), 16'h0);
    chk("async_active", 16'(bus.active), 16'h0);
    model_reset();
    #2 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("postrst_active", 16'(bus.active), 16'h0);
      chk("postrst_paddr", 16'(bus.paddr), 16'h0);
    end
    frame_start('0);
    probe(100, 512); chk("postrst_draw", 16'(last_paddr), 16'h400);

    // Randomized frames against the model.
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < N; i++)
        set_fret(i, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 200)) : int'($urandom_range(0, 1023)));
      bus.pressed = N'($urandom);
      frame_start(($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
      for (int p = 0; p < 25; p++) begin
        int h, v, k;
        k = int'($urandom_range(0, N - 1));
        h = ($urandom_range(0, 1) != 0) ? m_x[k] + int'($urandom_range(0, 40)) - 4 : int'($urandom_range(1, 1100));
        if (h < 1) h = 1;
        if (h > 2047) h = 2047;
        v = int'($urandom_range(505, 550));
        if (p == 10) begin
          set_fret(k, int'($urandom_range(0, 1023)));
          bus.pressed = N'($urandom);
        end
        if (p == 15 && $urandom_range(0, 1) != 0) pulse_hit(N'($urandom));
        probe(h, v);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fret_sprite_scheduler.md
Name: fret_sprite_scheduler

Overview:
- Shares one synchronous-read fret sprite ROM among N_FRETS fret sprites on the fret row.
- Latches fret positions and button state once per video frame, so they never change mid-frame.
- Tracks a per-fret hit-flash timer.
- For every pixel, selects the fret that owns it, builds the ROM address including an animation frame index, and returns the ROM pixel in step with the video pipeline.
- Sits between the game-state logic and the pixel mixer; replaces per-fret ROM instances.

Parameters:
- N_FRETS, 5, number of frets sharing the ROM.
- Y, 512, top scanline of the fret row.
- W, 32, sprite width in pixels; fixed at 32 by the address packing.
- H, 32, sprite height in pixels; fixed at 32 by the address packing.
- FLASH_FRAMES, 8, number of video frames the hit sprite is shown after a hit.
- TRANSPARENT, 13'h0000, pixel value output when no fret covers the pixel.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hcount  in  11  current horizontal pixel
- vcount  in  10  current scanline
- fret_x  in  10*N_FRETS  packed left-edge x of each fret; fret i occupies bits [10i+9:10i]
- pressed  in  N_FRETS  fret button held, level signal
- hit  in  N_FRETS  single-cycle pulse: note hit on fret i
- paddr  out  12  ROM address, {frame[1:0], yidx[4:0], xidx[4:0]}
- pdata  in  13  ROM data, valid one clk after paddr
- pixel  out  13  output pixel
- active  out  1  pixel is non-TRANSPARENT-sourced (a fret owns it), aligned with pixel

Behaviour:
- Reset (async): all of the following clear, and stay clear until the first frame-start.
  - Outputs: paddr=0, pixel=TRANSPARENT, active=0.
  - State: shadow registers, pipeline valid bits, flash counters, hit_pending, shadow_valid.
  - No fret is drawn while shadow_valid=0.
- Frame-start (FS) is defined as hcount==0 && vcount==0, sampled on clk. On FS:
  - Latch fret_x into shadow_x; latch pressed into shadow_pressed; set shadow_valid=1.
  - flash[i]: if hit_pending[i], load FLASH_FRAMES; else if flash[i]!=0, decrement by 1.
  - Clear hit_pending.
- hit pulses set hit_pending[i] on any cycle.
  - A hit on the FS cycle itself is kept pending for the next FS, not lost.
  - A re-hit while flashing reloads the counter at the next FS.
- Frame select per fret:
  - 2 if flash[i]!=0, else 1 if shadow_pressed[i], else 0.
  - Value 3 is never generated.
- Stage 0 (combinational on hcount/vcount):
  - xidx_i = hcount - shadow_x[i], 11-bit unsigned; values below 0 wrap large and fail the bound check.
  - yidx = vcount - Y, 10-bit unsigned.
  - in_i = shadow_valid && xidx_i<W && yidx<H.
- Arbitration: fixed priority, lowest index wins when fret sprites overlap.
  - The winner is decided by coverage only.
  - A TRANSPARENT ROM pixel from the winner does NOT fall through to a lower-priority fret.
- Stage 1 (registered):
  - With a winner: paddr <= {frame_w, yidx[4:0], xidx_w[4:0]}, v1 <= 1.
  - With no winner: paddr <= 0, v1 <= 0.
- Stage 2: the ROM returns pdata; v2 <= v1.
- Stage 3 (registered): pixel <= v2 ? pdata : TRANSPARENT; active <= v2.
- Latency: 1 clk hcount->paddr; 3 clk hcount->pixel. Upstream delays sync signals by 3 to match.
- Shadow state changes only on FS. Changing fret_x or pressed mid-frame has no visible effect until the next frame.
- Reset asserted mid-line: pipeline flushes immediately, and output is TRANSPARENT until after the next FS.

Test Plan:
- Reset, then draw 1 frame without FS → pixel stays 0 and active=0 throughout. Apply FS with fret_x[0]=100, then hcount=100, vcount=512 → paddr=12'h000 one clk later; pdata=13'h1ABC returned → pixel=13'h1ABC 3 clk after hcount.
- fret_x[0]=100, fret_x[1]=110, hcount=115, vcount=520 → fret 0 wins; paddr={2'd0,5'd8,5'd15}=12'h10F. Then hcount=135 → fret 1 wins; xidx=25, paddr=12'h119.
- Boundary checks:
  - hcount=99 or 132 with fret_x=100 → active=0.
  - vcount=511 or 544 → active=0.
  - fret_x=1020, hcount=5 → no wrap-around hit, active=0.
- pressed[2]=1 latched at FS, fret 2 at x=300, pixel (300,512) → paddr=12'h400. Deassert pressed mid-frame → paddr unchanged until the next FS, then 12'h000.
- Pulse hit[3] mid-frame → frame 2 (paddr[11:10]=2) shown for exactly 8 frames starting at the next FS, then frame 0. Pulse hit[3] on the FS cycle → flash starts one FS later.
- Assert reset during a drawn pixel → paddr=0 and pixel=0 immediately (async), with no drawing until the first FS after reset release.
